// File: rtl/step_motor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : step_motor_ctrl
// Brief   : Closed-count position controller for a 4-coil unipolar stepper.
// Revision: 1.0 - initial release
// ============================================================================
module step_motor_ctrl #(
  parameter int POS_W   = 12,
  parameter int MAX_POS = 4095,
  parameter int DIV_NUM = 100000,
  parameter int HOLD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             half_step,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic             abort,
  input  logic             home,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic [3:0]       signal
);

  localparam int               CNT_W      = (DIV_NUM > 1) ? $clog2(DIV_NUM) : 1;
  localparam logic [POS_W-1:0] c_max_pos  = POS_W'(MAX_POS);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV_NUM - 1);
  localparam bit               c_hold     = (HOLD_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] r_target;
  logic [2:0]       r_phase;
  logic             r_half;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_signal;

  logic             w_accept;
  logic [POS_W-1:0] w_tgt_clamped;
  logic             w_tick_end;
  logic             w_dir_up;
  logic [POS_W-1:0] w_pos_step;
  logic [2:0]       w_phase_delta;
  logic [2:0]       w_phase_step;
  logic [2:0]       w_phase_accept;
  logic [3:0]       w_idle_sig;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    case (idx)
      3'd0: phase_pattern = 4'b1000;
      3'd1: phase_pattern = 4'b1100;
      3'd2: phase_pattern = 4'b0100;
      3'd3: phase_pattern = 4'b0110;
      3'd4: phase_pattern = 4'b0010;
      3'd5: phase_pattern = 4'b0011;
      3'd6: phase_pattern = 4'b0001;
      3'd7: phase_pattern = 4'b1001;
    endcase
  endfunction

  // home has priority over a command in the same cycle
  assign cmd_ready     = (r_state == S_IDLE) && !home;
  assign w_accept      = cmd_ready && cmd_valid;
  assign w_tgt_clamped = (cmd_target > c_max_pos) ? c_max_pos : cmd_target;

  assign w_tick_end    = (r_cnt == c_cnt_last);
  assign w_dir_up      = (r_target > r_position);
  assign w_pos_step    = w_dir_up ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));

  // Full-step runs on the odd (two-coil) indices only, hence the +-2 stride
  assign w_phase_delta  = r_half ? 3'd1 : 3'd2;
  assign w_phase_step   = w_dir_up ? (r_phase + w_phase_delta) : (r_phase - w_phase_delta);
  assign w_phase_accept = (!half_step && !r_phase[0]) ? (r_phase + 3'd1) : r_phase;

  assign w_idle_sig = c_hold ? phase_pattern(r_phase) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_tgt_clamped == r_position) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_next = S_DONE;
        end else if (w_tick_end && (w_pos_step == r_target)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_position <= '0;
      r_target   <= '0;
      r_phase    <= 3'd1;
      r_half     <= 1'b0;
      r_cnt      <= '0;
      r_signal   <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_signal <= w_idle_sig;
          if (home) begin
            r_position <= '0;
          end else if (w_accept) begin
            r_target <= w_tgt_clamped;
            r_half   <= half_step;
            r_cnt    <= '0;
            r_phase  <= w_phase_accept;
            if (w_tgt_clamped != r_position) begin
              r_signal <= phase_pattern(w_phase_accept);
            end else begin
              r_signal <= r_signal;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_cnt <= '0;
          end else if (w_tick_end) begin
            r_cnt      <= '0;
            r_position <= w_pos_step;
            r_phase    <= w_phase_step;
            r_signal   <= phase_pattern(w_phase_step);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_signal <= w_idle_sig;
        end
        default: begin
          r_signal <= r_signal;
        end
      endcase
    end
  end

  assign position = r_position;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign signal   = r_signal;

endmodule
`default_nettype wire
